// File: rtl/pc_gen_pkg.sv
// Shared types for the PC generator: redirect kinds (ordered by priority),
// fetch FSM states and the sequential increment sizes.
package pc_gen_pkg;

   // Numeric order is priority order, so ">=" decides buffer replacement.
   typedef enum logic [1:0] {
      KIND_NONE   = 2'd0,
      KIND_BRANCH = 2'd1,
      KIND_ERET   = 2'd2,
      KIND_TRAP   = 2'd3
   } redirect_kind_t;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2
   } fsm_state_t;

   localparam int unsigned PC_INC_WORD = 4;
   localparam int unsigned PC_INC_HALF = 2;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending redirect buffer. A new redirect overwrites the held one
// only when its priority is equal or higher; clear empties it.
module pc_redirect_buf
   import pc_gen_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  redirect_kind_t  load_kind,
   input  logic [XLEN-1:0] load_addr,
   output logic            valid,
   output logic [XLEN-1:0] addr
);

   redirect_kind_t  kind_q;
   logic [XLEN-1:0] addr_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         kind_q <= KIND_NONE;
         addr_q <= '0;
      end else if ((load_kind != KIND_NONE) && (load_kind >= kind_q)) begin
         kind_q <= load_kind;
         addr_q <= load_addr;
      end
   end

   assign valid = (kind_q != KIND_NONE);
   assign addr  = addr_q;

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC register, next-PC priority select, boot delay FSM and bus handshake.
// Optional compressed-instruction support is enabled by defining PC_GEN_RVC_EN.
module pc_gen_unit
   import pc_gen_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] BOOT_ADDR = '0,
   parameter int unsigned     BOOT_WAIT = 1
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            ahb_ready_in,
   input  logic            stall_in,
   input  logic            trap_valid_in,
   input  logic [XLEN-1:0] trap_addr_in,
   input  logic            eret_valid_in,
   input  logic [XLEN-1:0] epc_in,
   input  logic            branch_valid_in,
   input  logic [XLEN-1:0] branch_addr_in,
`ifdef PC_GEN_RVC_EN
   input  logic            instr_len16_in,
`endif
   output logic            ireq_out,
   output logic [XLEN-1:0] iaddr_out,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus_4_out,
   output logic            mis_instr_out,
   output logic [XLEN-1:0] mis_addr_out,
   output fsm_state_t      fsm_state
);

   fsm_state_t      state, state_next;
   logic [3:0]      cnt, cnt_next;
   logic [XLEN-1:0] pc, pc_next, inc, branch_tgt, mis_addr;
   logic            advance, branch_mis, mis_fire, mis_instr;
   logic            buf_valid;
   logic [XLEN-1:0] buf_addr, load_addr;
   redirect_kind_t  load_kind;

   always_comb begin
      branch_tgt = branch_addr_in & ~XLEN'(1);
`ifdef PC_GEN_RVC_EN
      branch_mis = 1'b0;
      inc        = instr_len16_in ? XLEN'(PC_INC_HALF) : XLEN'(PC_INC_WORD);
`else
      branch_mis = branch_addr_in[1];
      inc        = XLEN'(PC_INC_WORD);
`endif
   end

   assign advance = (state != S_BOOT) && ahb_ready_in && !stall_in;

   // Next PC on advance; on any other cycle the winning redirect goes to the buffer.
   always_comb begin
      pc_next   = pc;
      mis_fire  = 1'b0;
      load_kind = KIND_NONE;
      load_addr = '0;
      if (advance) begin
         if (trap_valid_in)       pc_next = trap_addr_in;
         else if (eret_valid_in)  pc_next = epc_in;
         else if (buf_valid)      pc_next = buf_addr;
         else if (branch_valid_in) begin
            if (branch_mis) begin
               pc_next  = pc + inc;
               mis_fire = 1'b1;
            end else begin
               pc_next  = branch_tgt;
            end
         end else begin
            pc_next = pc + inc;
         end
      end else begin
         if (trap_valid_in) begin
            load_kind = KIND_TRAP;
            load_addr = trap_addr_in;
         end else if (eret_valid_in) begin
            load_kind = KIND_ERET;
            load_addr = epc_in;
         end else if (branch_valid_in) begin
            if (branch_mis) begin
               mis_fire = 1'b1;
            end else begin
               load_kind = KIND_BRANCH;
               load_addr = branch_tgt;
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         S_BOOT: begin
            if (cnt <= 4'd1) state_next = S_RUN;
            else             cnt_next   = cnt - 4'd1;
         end
         S_RUN:   if (!ahb_ready_in) state_next = S_WAIT;
         S_WAIT:  if (advance)       state_next = S_RUN;
         default: state_next = S_BOOT;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state     <= S_BOOT;
         cnt       <= 4'(BOOT_WAIT);
         pc        <= BOOT_ADDR;
         mis_instr <= 1'b0;
         mis_addr  <= '0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         pc        <= pc_next;
         mis_instr <= mis_fire;
         if (mis_fire) mis_addr <= branch_tgt;
      end
   end

   // Every advance either consumes or supersedes the pending entry.
   pc_redirect_buf #(.XLEN(XLEN)) u_buf (
      .clk       (clk_in),
      .rst       (rst_in),
      .clear     (advance),
      .load_kind (load_kind),
      .load_addr (load_addr),
      .valid     (buf_valid),
      .addr      (buf_addr)
   );

   assign ireq_out      = (state != S_BOOT);
   assign iaddr_out     = pc;
   assign pc_out        = pc;
   assign pc_plus_4_out = pc + XLEN'(PC_INC_WORD);
   assign mis_instr_out = mis_instr;
   assign mis_addr_out  = mis_addr;
   assign fsm_state     = state;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Vector-table bench for pc_gen_unit (BOOT_ADDR 0x100, BOOT_WAIT 2) followed
// by a short random ready/stall run against a sequential PC model.
module tb_pc_gen_unit;
  import pc_gen_pkg::*;

  localparam int W = 32;

`ifdef PC_GEN_RVC_EN
  localparam logic [W-1:0] MIS_A  = 32'h0;
  localparam logic         MIS_P  = 1'b0;
  localparam logic [W-1:0] A_402  = 32'h402;
  localparam logic [W-1:0] A_NEXT = 32'h406;
`else
  localparam logic [W-1:0] MIS_A  = 32'h402;
  localparam logic         MIS_P  = 1'b1;
  localparam logic [W-1:0] A_402  = 32'h404;
  localparam logic [W-1:0] A_NEXT = 32'h408;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, ready, stall, tv, ev, bv, len16;
  logic [W-1:0] ta, ea, ba;
  logic         ireq, mis;
  logic [W-1:0] iaddr, pc, pc4, maddr;
  fsm_state_t   st;

  pc_gen_unit #(.XLEN(W), .BOOT_ADDR(32'h100), .BOOT_WAIT(2)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .ahb_ready_in    (ready),
    .stall_in        (stall),
    .trap_valid_in   (tv),
    .trap_addr_in    (ta),
    .eret_valid_in   (ev),
    .epc_in          (ea),
    .branch_valid_in (bv),
    .branch_addr_in  (ba),
`ifdef PC_GEN_RVC_EN
    .instr_len16_in  (len16),
`endif
    .ireq_out        (ireq),
    .iaddr_out       (iaddr),
    .pc_out          (pc),
    .pc_plus_4_out   (pc4),
    .mis_instr_out   (mis),
    .mis_addr_out    (maddr),
    .fsm_state       (st)
  );

  typedef struct {
    logic         rst, ready, stall, tv, ev, bv;
    logic [W-1:0] ta, ea, ba;
    logic         e_ireq, e_mis;
    logic [W-1:0] e_iaddr, e_maddr;
  } vec_t;

  vec_t vecs[$];
  // scoreboard entry: {ireq, mis, mis_addr, iaddr}
  logic [2*W+1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic r, input logic rdy, input logic stl,
                     input logic t, input logic [W-1:0] t_a,
                     input logic e, input logic [W-1:0] e_a,
                     input logic b, input logic [W-1:0] b_a,
                     input logic x_ireq, input logic [W-1:0] x_iaddr,
                     input logic x_mis, input logic [W-1:0] x_maddr);
    vec_t v;
    v.rst = r; v.ready = rdy; v.stall = stl;
    v.tv = t; v.ta = t_a; v.ev = e; v.ea = e_a; v.bv = b; v.ba = b_a;
    v.e_ireq = x_ireq; v.e_iaddr = x_iaddr; v.e_mis = x_mis; v.e_maddr = x_maddr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; ready = v.ready; stall = v.stall;
    tv = v.tv; ta = v.ta; ev = v.ev; ea = v.ea; bv = v.bv; ba = v.ba;
  endtask

  task automatic compare_out(input int idx);
    logic [2*W+1:0] e;
    string tag;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty at step %0d", idx);
      return;
    end
    e = exp_q.pop_front();
    tag = $sformatf("step%0d", idx);
    check({tag, "_ireq"},  W'(ireq),  W'(e[2*W+1]));
    check({tag, "_iaddr"}, iaddr,     e[W-1:0]);
    check({tag, "_pc"},    pc,        e[W-1:0]);
    check({tag, "_pc4"},   pc4,       e[W-1:0] + 32'd4);
    check({tag, "_mis"},   W'(mis),   W'(e[2*W]));
    check({tag, "_maddr"}, maddr,     e[2*W-1:W]);
  endtask

  initial begin
    logic [W-1:0] model_pc;
    rst = 1'b1; ready = 1'b0; stall = 1'b0; len16 = 1'b0;
    tv = 1'b0; ev = 1'b0; bv = 1'b0; ta = '0; ea = '0; ba = '0;

    //  rst rdy stl  tv ta            ev ea       bv ba        ireq iaddr          mis    maddr
    add(1, 1, 0,  0, 0,            0, 0,       0, 0,        0, 32'h100,        0,     0);
    add(1, 1, 0,  0, 0,            0, 0,       0, 0,        0, 32'h100,        0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        0, 32'h100,        0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, 32'h100,        0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, 32'h104,        0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, 32'h108,        0,     0);
    add(0, 1, 0,  1, 32'h200,      0, 0,       0, 0,        1, 32'h200,        0,     0);
    add(0, 0, 0,  0, 0,            0, 0,       0, 0,        1, 32'h200,        0,     0);
    add(0, 0, 0,  0, 0,            0, 0,       0, 0,        1, 32'h200,        0,     0);
    add(0, 0, 0,  0, 0,            0, 0,       0, 0,        1, 32'h200,        0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, 32'h204,        0,     0);
    add(0, 1, 1,  0, 0,            0, 0,       0, 0,        1, 32'h204,        0,     0);
    // pending branch replaced by trap, later lower-priority branch dropped
    add(0, 0, 0,  0, 0,            0, 0,       1, 32'h400,  1, 32'h204,        0,     0);
    add(0, 0, 0,  1, 32'h80,       0, 0,       0, 0,        1, 32'h204,        0,     0);
    add(0, 0, 0,  0, 0,            0, 0,       1, 32'h600,  1, 32'h204,        0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, 32'h80,         0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, 32'h84,         0,     0);
    // simultaneous redirects on an advance
    add(0, 1, 0,  1, 32'h80,       1, 32'h300, 1, 32'h500,  1, 32'h80,         0,     0);
    add(0, 1, 0,  0, 0,            1, 32'h300, 1, 32'h500,  1, 32'h300,        0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       1, 32'h400,  1, 32'h400,        0,     0);
    // misaligned target
    add(0, 1, 0,  0, 0,            0, 0,       1, 32'h402,  1, A_402,          MIS_P, MIS_A);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, A_NEXT,         0,     MIS_A);
    add(0, 1, 0,  0, 0,            0, 0,       1, 32'h501,  1, 32'h500,        0,     MIS_A);
    // wrap-around
    add(0, 1, 0,  1, 32'hFFFF_FFFC, 0, 0,      0, 0,        1, 32'hFFFF_FFFC,  0,     MIS_A);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, 32'h0,          0,     MIS_A);
    // reset in S_WAIT with a pending branch
    add(0, 0, 0,  0, 0,            0, 0,       1, 32'h700,  1, 32'h0,          0,     MIS_A);
    add(1, 0, 0,  0, 0,            0, 0,       0, 0,        0, 32'h100,        0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        0, 32'h100,        0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, 32'h100,        0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, 32'h104,        0,     0);
    // equal priority replaces
    add(0, 0, 0,  0, 0,            0, 0,       1, 32'h800,  1, 32'h104,        0,     0);
    add(0, 0, 0,  0, 0,            0, 0,       1, 32'h840,  1, 32'h104,        0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, 32'h840,        0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, 32'h844,        0,     0);
    // trap supersedes a pending eret and clears it
    add(0, 0, 0,  0, 0,            1, 32'h300, 0, 0,        1, 32'h844,        0,     0);
    add(0, 1, 0,  1, 32'h88,       0, 0,       0, 0,        1, 32'h88,         0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, 32'h8C,         0,     0);
    // pending branch beats a fresh branch on the consuming cycle
    add(0, 1, 1,  0, 0,            0, 0,       1, 32'hA00,  1, 32'h8C,         0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       1, 32'hB00,  1, 32'hA00,        0,     0);
    add(0, 1, 0,  0, 0,            0, 0,       0, 0,        1, 32'hA04,        0,     0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back({vecs[i].e_ireq, vecs[i].e_mis, vecs[i].e_maddr, vecs[i].e_iaddr});
      @(posedge clk);
      #1;
      compare_out(i);
    end

    // random ready/stall with no redirects: PC advances by 4 on ready & !stall
    model_pc = 32'hA04;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rst = 1'b0; tv = 1'b0; ev = 1'b0; bv = 1'b0;
      ready = 1'($urandom_range(0, 3) != 0);
      stall = 1'($urandom_range(0, 3) == 0);
      if (ready && !stall) model_pc = model_pc + 32'd4;
      exp_q.push_back({1'b1, 1'b0, 32'h0, model_pc});
      @(posedge clk);
      #1;
      compare_out(1000 + i);
    end

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
